// File: rtl/aes_wb_sequencer.sv
// aes_wb_sequencer
//   Wishbone-slave control front end for the AES core. It holds the key,
//   input-block and result registers, and runs the core through optional key
//   expansion followed by one encrypt/decrypt block. Completion is reported
//   through sticky STATUS bits and an optional level interrupt.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_*                   Wishbone classic slave (2-cycle access, registered read)
//   core_key/din/mode       register contents driven straight to the core
//   core_key_load/start     one-cycle pulses on the first cycle of KEYX/RUN
//   core_key_rdy/done/dout  core completion pulses and result block
//   core_abort              one-cycle pulse when a wait times out
//   irq                     level interrupt
//
// Parameter
//   TIMEOUT_CYCLES          wait limit in KEYX/RUN (2..65535)
//
// Build option
//   AES_SEQ_IRQ_EN          when defined, CTRL.b3 (IRQ_EN) exists and irq is a
//                           registered IRQ_EN & (DONE|TMO|ERR); otherwise irq = 0
//                           and CTRL.b3 reads 0.
module aes_wb_sequencer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] core_key,
  output logic         core_key_load,
  input  logic         core_key_rdy,
  output logic [127:0] core_din,
  output logic         core_mode,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_dout,
  output logic         core_abort,
  output logic         irq
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, KEYX, RUN, CAPT} state_t;

  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         ack_q, ack_d;
  logic [31:0]  dat_q, dat_d;
  logic [127:0] key_q, key_d, din_q, din_d, dout_q, dout_d;
  logic         mode_q, mode_d, key_new_q, key_new_d, irq_en_q, irq_en_d;
  logic         done_q, done_d, err_q, err_d, tmo_q, tmo_d;
  logic         key_dirty_q, key_dirty_d;
  logic [7:0]   jobs_q, jobs_d;

  logic [3:0]   word;
  logic [6:0]   woff;
  logic [31:0]  rd_data;
  logic         access, wr, busy, is_ctrl, is_stat, is_key, is_din;
  logic         busy_err, start_go, done_set, tmo_set;
  logic         unused_adr_bits;

  assign word    = wbs_adr_i[5:2];
  // Word 0 of a 128-bit register sits at [127:96], so the bit offset is (3-w)*32.
  assign woff    = {~word[1:0], 5'b0};
  assign access  = wbs_cyc_i & wbs_stb_i;
  assign wr      = access & wbs_we_i & ack_q;
  assign busy    = (state_q != IDLE);
  assign is_ctrl = (word == 4'd0);
  assign is_stat = (word == 4'd1);
  assign is_key  = (word[3:2] == 2'b01);
  assign is_din  = (word[3:2] == 2'b10);
  assign unused_adr_bits = ^{wbs_adr_i[31:6], wbs_adr_i[1:0]};

  // While busy, a KEY/DIN write, a START, or an attempt to change MODE is an error.
  assign busy_err = wr & busy & (is_key | is_din |
                    (is_ctrl & wbs_sel_i[0] & (wbs_dat_i[0] | (wbs_dat_i[1] != mode_q))));
  assign start_go = wr & ~busy & is_ctrl & wbs_sel_i[0] & wbs_dat_i[0];

  // Sequencer
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 16'd1;
    dout_d        = dout_q;
    core_key_load = 1'b0;
    core_start    = 1'b0;
    core_abort    = 1'b0;
    done_set      = 1'b0;
    tmo_set       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_go) state_d = (wbs_dat_i[2] | key_dirty_q) ? KEYX : RUN;
      end
      KEYX: begin
        core_key_load = (cnt_q == '0);
        if (core_key_rdy) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LIM) begin
          core_abort = 1'b1;
          tmo_set    = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      RUN: begin
        core_start = (cnt_q == '0);
        // core_done is checked first so it wins over a same-cycle timeout.
        if (core_done) begin
          dout_d  = core_dout;
          state_d = CAPT;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LIM) begin
          core_abort = 1'b1;
          tmo_set    = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      CAPT: begin
        done_set = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read mux
  always_comb begin
    rd_data = '0;
    case (word)
      4'd0:                      rd_data = {28'b0, irq_en_q, key_new_q, mode_q, 1'b0};
      4'd1:                      rd_data = {16'b0, jobs_q, 4'b0, tmo_q, err_q, done_q, busy};
      4'd4, 4'd5, 4'd6, 4'd7:    rd_data = key_q[woff +: 32];
      4'd8, 4'd9, 4'd10, 4'd11:  rd_data = din_q[woff +: 32];
      4'd12, 4'd13, 4'd14, 4'd15: rd_data = dout_q[woff +: 32];
      default:                   rd_data = '0;
    endcase
  end

  // Register file and status
  always_comb begin
    ack_d       = access & ~ack_q;
    dat_d       = ack_d ? rd_data : '0;
    key_d       = key_q;
    din_d       = din_q;
    mode_d      = mode_q;
    key_new_d   = key_new_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    key_dirty_d = key_dirty_q;
    jobs_d      = done_set ? jobs_q + 8'd1 : jobs_q;

    if (wr) begin
      if (is_ctrl && wbs_sel_i[0]) begin
        if (!busy) mode_d = wbs_dat_i[1];
        key_new_d = wbs_dat_i[2];
`ifdef AES_SEQ_IRQ_EN
        irq_en_d = wbs_dat_i[3];
`endif
      end
      if (is_stat && wbs_sel_i[0]) begin
        if (wbs_dat_i[1]) done_d = 1'b0;
        if (wbs_dat_i[2]) err_d  = 1'b0;
        if (wbs_dat_i[3]) tmo_d  = 1'b0;
      end
      if (!busy && (is_key || is_din)) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) begin
            if (is_key) key_d[woff + 7'(8 * b) +: 8] = wbs_dat_i[8 * b +: 8];
            else        din_d[woff + 7'(8 * b) +: 8] = wbs_dat_i[8 * b +: 8];
          end
        end
        if (is_key) key_dirty_d = 1'b1;
      end
    end

    if (state_q == KEYX && core_key_rdy) key_dirty_d = 1'b0;
    // Hardware sets come last so they win over a same-cycle W1C.
    if (done_set) done_d = 1'b1;
    if (busy_err) err_d  = 1'b1;
    if (tmo_set)  tmo_d  = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      key_q       <= '0;
      din_q       <= '0;
      dout_q      <= '0;
      mode_q      <= 1'b0;
      key_new_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      key_dirty_q <= 1'b0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      key_q       <= key_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      mode_q      <= mode_d;
      key_new_q   <= key_new_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      key_dirty_q <= key_dirty_d;
      jobs_q      <= jobs_d;
    end
  end

`ifdef AES_SEQ_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = irq_en_q & (done_q | tmo_q | err_q);
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign core_key  = key_q;
  assign core_din  = din_q;
  assign core_mode = mode_q;

endmodule

// File: tb/tb_aes_wb_sequencer.sv
// Testbench for aes_wb_sequencer: register reads are checked by a scoreboard
// monitor, the bench plays the AES core with programmable latencies.
module tb_aes_wb_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i, wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [127:0] core_key, core_din, core_dout;
  logic         core_key_load, core_key_rdy, core_mode, core_start, core_done;
  logic         core_abort, irq;

`ifdef AES_SEQ_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  aes_wb_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_key(core_key), .core_key_load(core_key_load), .core_key_rdy(core_key_rdy),
    .core_din(core_din), .core_mode(core_mode), .core_start(core_start),
    .core_done(core_done), .core_dout(core_dout), .core_abort(core_abort),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: each read pushes its expected word; the monitor pops on ack.
  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [31:0] mon_exp;
  string       mon_nm;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && wbs_ack_o === 1'b1 && wbs_we_i === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: data %h with nothing queued", wbs_dat_o);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_nm  = nm_q.pop_front();
          $display("txn read  adr=%h data=%h expect=%h (%s)", wbs_adr_i, wbs_dat_o, mon_exp, mon_nm);
          check(mon_nm, {96'b0, wbs_dat_o}, {96'b0, mon_exp});
        end
      end
    end
  end

  // Pulse monitor
  int n_kl = 0, n_st = 0, n_ab = 0;
  int kl_cyc = 0, st_cyc = 0, ab_cyc = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (core_key_load === 1'b1) begin n_kl++; kl_cyc = cyc_cnt; end
      if (core_start === 1'b1)    begin n_st++; st_cyc = cyc_cnt; end
      if (core_abort === 1'b1)    begin n_ab++; ab_cyc = cyc_cnt; end
    end
  end

  // Core model
  int           key_lat = 3;
  int           run_lat = 5;
  bit           done_en = 1'b1;
  logic [127:0] resp = '0;
  logic [127:0] cap_key = '0, cap_din = '0;
  logic         cap_mode = 1'b0;
  initial begin
    core_key_rdy = 1'b0;
    core_done    = 1'b0;
    core_dout    = '0;
    forever begin
      @(posedge clk); #1;
      core_key_rdy = 1'b0;
      core_done    = 1'b0;
      if (core_key_load === 1'b1) begin
        repeat (key_lat) begin @(posedge clk); #1; end
        core_key_rdy = 1'b1;
      end else if (core_start === 1'b1) begin
        cap_key  = core_key;
        cap_din  = core_din;
        cap_mode = core_mode;
        if (done_en) begin
          repeat (run_lat) begin @(posedge clk); #1; end
          core_done = 1'b1;
          core_dout = resp;
        end
      end
    end
  end

  int commit_cyc = 0;
  task automatic wb_xfer(input logic [7:0] adr, input logic [31:0] data,
                         input logic [3:0] sel, input logic we);
    int n;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = {24'h0, adr}; wbs_dat_i = data; wbs_sel_i = sel;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (wbs_ack_o !== 1'b1 && n < 16);
    if (wbs_ack_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: adr %h got no ack, required ack within 16 cycles", adr);
    end
    @(posedge clk); #1;
    commit_cyc = cyc_cnt;
    if (we) $display("txn write adr=%h data=%h sel=%h", adr, data, sel);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] data, input logic [3:0] sel);
    wb_xfer(adr, data, sel, 1'b1);
  endtask

  task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    nm_q.push_back(name);
    wb_xfer(adr, 32'h0, 4'h0, 1'b0);
  endtask

  logic [127:0] key_vec = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] pt_vec  = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] ct1     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] ct2     = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  task automatic load_key_din();
    for (int i = 0; i < 4; i++) begin
      wr(8'h10 + 8'(4 * i), key_vec[(3 - i) * 32 +: 32], 4'hf);
      wr(8'h20 + 8'(4 * i), pt_vec[(3 - i) * 32 +: 32], 4'hf);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int n;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {wbs_ack_o, irq, core_key_load, core_start, core_abort}, 5'b0);
    check("reset_dat_o", wbs_dat_o, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    rd(8'h04, 32'h0, "status_reset");
    check("ack_one_cycle", wbs_ack_o, 1'b0);
    rd(8'h00, 32'h0, "ctrl_reset");

    // Encrypt with key expansion
    load_key_din();
    rd(8'h1C, 32'h0c0d0e0f, "key3_readback");
    key_lat = 3; run_lat = 5; resp = ct1; done_en = 1'b1;
    wr(8'h00, 32'h1, 4'hf);
    c0 = commit_cyc;
    repeat (20) @(posedge clk);
    check("job1_key_load_count", n_kl, 1);
    check("job1_key_load_cycle", kl_cyc, c0);
    check("job1_start_count", n_st, 1);
    check("job1_start_cycle", st_cyc, c0 + 4);
    check("job1_core_key", cap_key, key_vec);
    check("job1_core_din", cap_din, pt_vec);
    check("job1_core_mode", cap_mode, 1'b0);
    for (int i = 0; i < 4; i++) rd(8'h30 + 8'(4 * i), ct1[(3 - i) * 32 +: 32], "job1_dout");
    rd(8'h04, 32'h0102, "status_job1");

    // Cached key
    wr(8'h00, 32'h1, 4'hf);
    c0 = commit_cyc;
    repeat (15) @(posedge clk);
    check("job2_no_key_load", n_kl, 1);
    check("job2_start_count", n_st, 2);
    check("job2_start_cycle", st_cyc, c0);
    rd(8'h04, 32'h0202, "status_job2");

    // Byte enables and unmapped address
    wr(8'h2C, 32'haaaaaaaa, 4'b0010);
    rd(8'h2C, 32'hccddaaff, "din3_byte_enable");
    wr(8'h08, 32'hffffffff, 4'hf);
    rd(8'h08, 32'h0, "unmapped_read");

    // Busy protection
    run_lat = 12;
    wr(8'h00, 32'h1, 4'hf);
    wr(8'h20, 32'hdeadbeef, 4'hf);
    wr(8'h00, 32'h1, 4'hf);
    rd(8'h04, 32'h0207, "status_while_busy");
    repeat (20) @(posedge clk);
    check("busy_single_start", n_st, 3);
    rd(8'h20, 32'h00112233, "din0_busy_protect");
    rd(8'h04, 32'h0306, "status_busy_err");
    wr(8'h04, 32'h4, 4'b0001);
    rd(8'h04, 32'h0302, "status_err_w1c");

    // Timeout
    wr(8'h04, 32'h2, 4'b0001);
    done_en = 1'b0;
    wr(8'h00, 32'h1, 4'hf);
    c0 = commit_cyc;
    repeat (25) @(posedge clk);
    check("tmo_abort_count", n_ab, 1);
    check("tmo_abort_cycle", ab_cyc, c0 + 16);
    check("tmo_start_count", n_st, 4);
    rd(8'h04, 32'h0308, "status_timeout");
    rd(8'h30, 32'h69c4e0d8, "dout0_after_timeout");

    // Collision: done on the timeout cycle, DONE W1C on the CAPT edge
    wr(8'h04, 32'h8, 4'b0001);
    rd(8'h04, 32'h0300, "status_tmo_w1c");
    done_en = 1'b1; run_lat = 16; resp = ct2;
    wr(8'h00, 32'h1, 4'hf);
    c0 = commit_cyc;
    n = 0;
    while (cyc_cnt < c0 + 15 && n < 100) begin @(posedge clk); #1; n++; end
    wr(8'h04, 32'h2, 4'b0001);
    repeat (5) @(posedge clk);
    check("collision_no_abort", n_ab, 1);
    check("collision_start_count", n_st, 5);
    rd(8'h04, 32'h0402, "status_collision");
    rd(8'h30, 32'h0f1e2d3c, "dout0_collision");
    rd(8'h3C, 32'hc3d2e1f0, "dout3_collision");

    // Reset mid-RUN
    done_en = 1'b0;
    wr(8'h00, 32'h1, 4'hf);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mid_irq", irq, 1'b0);
    check("reset_mid_pulses", {core_start, core_abort, core_key_load, wbs_ack_o}, 4'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (25) @(posedge clk);
    check("reset_mid_no_abort", n_ab, 1);
    rd(8'h04, 32'h0, "status_after_reset");
    rd(8'h30, 32'h0, "dout0_after_reset");

    // IRQ enable and decrypt mode
    load_key_din();
    wr(8'h00, 32'h8, 4'hf);
    rd(8'h00, IRQ_BUILD ? 32'h8 : 32'h0, "ctrl_irq_en");
    check("irq_before_job", irq, 1'b0);
    done_en = 1'b1; key_lat = 2; run_lat = 4; resp = ct1;
    wr(8'h00, 32'hB, 4'hf);
    repeat (20) @(posedge clk);
    check("job_dec_key_load_count", n_kl, 2);
    check("job_dec_mode", cap_mode, 1'b1);
    rd(8'h04, 32'h0102, "status_dec_job");
    rd(8'h00, IRQ_BUILD ? 32'hA : 32'h2, "ctrl_after_dec");
    check("irq_after_done", irq, IRQ_BUILD);

    check("pending_reads", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_wb_sequencer.md
# aes_wb_sequencer

Wishbone-slave control front end that sequences the AES core inside the user project. It holds the key, input block and result registers, and drives the core through key expansion and a single-block encrypt or decrypt. It reports completion through sticky status bits and a level interrupt. It sits between the management SoC Wishbone port and the AES datapath.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum wait cycles in KEYX or RUN before abort; legal range 2..65535.
- `wb_clk_i` in 1: clock; all logic is on the rising edge.
- `wb_rst_i` in 1: reset, asynchronous and active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone classic cycle, strobe and write enable.
- `wbs_sel_i` in 4: byte enables for writes.
- `wbs_adr_i` in 32: byte address; only bits [5:2] are decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `core_key` out 128: key to the core.
- `core_key_load` out 1: one-cycle pulse that starts key expansion.
- `core_key_rdy` in 1: key expansion complete; single-cycle pulse.
- `core_din` out 128: input block to the core.
- `core_mode` out 1: 0 = encrypt, 1 = decrypt.
- `core_start` out 1: one-cycle pulse that starts the block operation.
- `core_done` in 1: block complete; single-cycle pulse; `core_dout` is valid in the same cycle.
- `core_dout` in 128: result block from the core.
- `core_abort` out 1: one-cycle pulse issued on timeout.
- `irq` out 1: level interrupt.

## Operation
- **Register map** (offset = adr[5:2]×4):
  - 0x00 CTRL: b0 START (self-clearing, reads 0), b1 MODE, b2 KEY_NEW, b3 IRQ_EN.
  - 0x04 STATUS: b0 BUSY (RO), b1 DONE (W1C), b2 ERR (W1C), b3 TMO (W1C), b[15:8] JOBS (RO, 8-bit wrapping count of completed jobs).
  - 0x10–0x1C KEY0..3.
  - 0x20–0x2C DIN0..3.
  - 0x30–0x3C DOUT0..3 (RO).
  - Word 0 maps to bits [127:96]; word 3 maps to bits [31:0].
  - Unmapped addresses read 0 and ignore writes.
- **Byte enables**: writes honour `wbs_sel_i` per byte. W1C and START act only on bytes whose select bit is set.
- **Key dirty flag**: set by any KEY write, cleared on `core_key_rdy`.
- **Writes while BUSY**: writes to KEY, DIN or MODE are dropped and set ERR. A START while BUSY is ignored and sets ERR.
- **FSM states**: IDLE, KEYX, RUN, CAPT.
  - IDLE: START with KEY_NEW=1 or the key dirty flag set → KEYX; otherwise START → RUN.
  - KEYX: `core_key_load` is high on the first cycle only. `core_key_rdy` → RUN.
  - RUN: `core_start` is high on the first cycle only. `core_done` → CAPT, with `core_dout` latched into DOUT on that edge.
  - CAPT: sets DONE, increments JOBS, returns to IDLE.
- **Timeout**: a wait counter resets on every state entry. If it reaches TIMEOUT_CYCLES in KEYX or RUN:
  - `core_abort` pulses for one cycle;
  - TMO is set and DONE is not set;
  - DOUT is unchanged and the FSM returns to IDLE.
- BUSY = (state != IDLE).
- `core_key`, `core_din` and `core_mode` drive straight from the registers, which are stable while BUSY.
- **Simultaneous events**:
  - `core_done` and timeout in the same cycle: done wins, no abort.
  - W1C and a hardware set of the same bit in the same cycle: the set wins.
  - `core_key_rdy` and `core_done` outside their wait state are ignored.
- **Reset values**:
  - All registers, JOBS and the FSM (IDLE) reset to 0.
  - `wbs_ack_o`, `wbs_dat_o`, `core_key_load`, `core_start`, `core_abort` and `irq` are 0 during reset.
  - Reset during KEYX or RUN returns to IDLE with no abort pulse; the core shares the same reset.

## Timing
- **Ack**: `wbs_ack_o` rises on the edge after `cyc & stb & !ack` and stays high for exactly one cycle. Each access therefore takes 2 cycles.
- **Write commit**: writes commit on the edge where `wbs_ack_o` is 1. Read data is registered and valid while ack is high.
- **START**: the FSM leaves IDLE on the edge after the START write commits. `core_start` or `core_key_load` is high in that first state cycle.
- **Completion**: DOUT updates on the edge that samples `core_done`. CAPT lasts 1 cycle, so DONE and JOBS update 1 cycle later and BUSY is 0 in the following cycle.
- **Minimum job time** without key expansion: 1 (RUN) + core latency + 1 (CAPT) cycles after the START commit.
- **Timeout**: `core_abort` is asserted TIMEOUT_CYCLES cycles after state entry.

## Configuration
- `AES_SEQ_IRQ_EN` defined: `irq` = IRQ_EN & (DONE | TMO | ERR), registered and updated 1 cycle after the source bit changes.
- `AES_SEQ_IRQ_EN` undefined: `irq` is tied to 0 and CTRL.b3 reads 0 and ignores writes. All other behaviour is identical.

## Test plan
- **Encrypt**: write the FIPS-197 C.1 key 000102..0f and plaintext 00112233..ff, then CTRL=0x1 → `core_key_load` once, then `core_start` once. DOUT = 69c4e0d8..c55a, DONE=1, JOBS=1, BUSY=0.
- **Cached key**: a second START with no KEY write and KEY_NEW=0 → no `core_key_load` pulse, `core_start` on the first cycle after commit, JOBS=2.
- **Busy protection**: write DIN0 and START while BUSY → DIN0 unchanged, ERR=1, no second `core_start`. W1C 0x4 to STATUS → ERR=0.
- **Timeout**: TIMEOUT_CYCLES=16 and `core_done` never asserted → `core_abort` 16 cycles after RUN entry, TMO=1, DONE=0, DOUT unchanged, BUSY=0.
- **Collision**: `core_done` in the same cycle the timeout is reached → DONE=1, TMO=0, no `core_abort`. A DONE W1C coinciding with the CAPT set → DONE stays 1.
- **Reset mid-job**: assert `wb_rst_i` mid-RUN → all STATUS bits 0, `irq`=0, no `core_abort`. With `AES_SEQ_IRQ_EN` and IRQ_EN=1, a completed job raises `irq` 1 cycle after DONE.
